seq_alu: RTL and testbench

- Parametrised, registered successor to the single-cycle datapath ALU. It adds iterative multiply/divide with HI/LO registers and a start/busy/done handshake.
- Sits in the EX stage. The pipeline stalls on busy for MULT/DIV; all other ops return one cycle after start.
- Same ALUCnt-style control, widened to 4 bits with extended opcodes.

---
 rtl/seq_alu.sv | 235 +++++++++++++++++++++++
 tb/tb_seq_alu.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered EX-stage ALU with iterative MULT/DIV, HI/LO registers and a start/busy/done handshake.
// Optional signed MULTS/DIVS (opcodes 13/14) are enabled by defining SEQ_ALU_SIGNED_EN.
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALUCnt,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] ALU_result,
  output logic             Zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             div_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_MULT = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;
  localparam logic [3:0] OP_MFHI = 4'd10;
  localparam logic [3:0] OP_MFLO = 4'd11;
`ifdef SEQ_ALU_SIGNED_EN
  localparam logic [3:0] OP_MULTS = 4'd13;
  localparam logic [3:0] OP_DIVS  = 4'd14;
`endif

  logic [1:0]       state, state_nxt;
  logic [SHW-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0] acc_hi, acc_hi_nxt;     // product high / partial remainder
  logic [WIDTH-1:0] acc_lo, acc_lo_nxt;     // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] opnd_b, opnd_b_nxt;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] opnd_a, opnd_a_nxt;     // raw dividend, kept for divide-by-zero
  logic             dz, dz_nxt;
  logic             neg_q, neg_q_nxt;
  logic             neg_r, neg_r_nxt;

  logic [WIDTH-1:0] result_nxt, hi_nxt, lo_nxt;
  logic             zero_nxt, busy_nxt, done_nxt, div_zero_nxt;

  logic [WIDTH-1:0] quick_c;
  logic [WIDTH:0]   mul_sum_c, r_sh_c, diff_c;
  logic [WIDTH-1:0] step_hi_c, step_lo_c;
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0] quo_c, rem_c, fin_hi_c, fin_lo_c;
`ifdef SEQ_ALU_SIGNED_EN
  logic [WIDTH-1:0] mag1_c, mag2_c;
`endif

  // Single-cycle result for every non-iterative opcode
  always_comb begin
    quick_c = '0;
    case (ALUCnt)
      OP_AND:  quick_c = input1 & input2;
      OP_OR:   quick_c = input1 | input2;
      OP_ADD:  quick_c = input1 + input2;
      OP_SUB:  quick_c = input1 - input2;
      OP_SLT:  quick_c = ($signed(input1) < $signed(input2)) ? WIDTH'(1) : '0;
      OP_NOR:  quick_c = ~(input1 | input2);
      OP_SLL:  quick_c = input2 << shamt;
      OP_SRL:  quick_c = input2 >> shamt;
      OP_MFHI: quick_c = HI;
      OP_MFLO: quick_c = LO;
      default: quick_c = '0;
    endcase
  end

  // One shift-add or restoring-subtract step, then the sign/zero-divisor fixup of that step
  always_comb begin
    mul_sum_c = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opnd_b}) : {1'b0, acc_hi};
    r_sh_c    = {acc_hi, acc_lo[WIDTH-1]};
    diff_c    = r_sh_c - {1'b0, opnd_b};
    if (state == S_DIV) begin
      step_hi_c = diff_c[WIDTH] ? r_sh_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
      step_lo_c = {acc_lo[WIDTH-2:0], ~diff_c[WIDTH]};
    end else begin
      step_hi_c = mul_sum_c[WIDTH:1];
      step_lo_c = {mul_sum_c[0], acc_lo[WIDTH-1:1]};
    end
    prod_c = {step_hi_c, step_lo_c};
    if (neg_q) prod_c = -prod_c;
    quo_c = neg_q ? -step_lo_c : step_lo_c;
    rem_c = neg_r ? -step_hi_c : step_hi_c;
    if (state == S_DIV) begin
      fin_hi_c = dz ? opnd_a : rem_c;
      fin_lo_c = dz ? '1 : quo_c;
    end else begin
      fin_hi_c = prod_c[2*WIDTH-1:WIDTH];
      fin_lo_c = prod_c[WIDTH-1:0];
    end
  end

`ifdef SEQ_ALU_SIGNED_EN
  assign mag1_c = input1[WIDTH-1] ? -input1 : input1;
  assign mag2_c = input2[WIDTH-1] ? -input2 : input2;
`endif

  // Next-state and output logic; FIN accepts a new start exactly like IDLE
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    acc_hi_nxt   = acc_hi;
    acc_lo_nxt   = acc_lo;
    opnd_b_nxt   = opnd_b;
    opnd_a_nxt   = opnd_a;
    dz_nxt       = dz;
    neg_q_nxt    = neg_q;
    neg_r_nxt    = neg_r;
    result_nxt   = ALU_result;
    zero_nxt     = Zero;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    hi_nxt       = HI;
    lo_nxt       = LO;
    div_zero_nxt = div_zero;

    case (state)
      S_MUL, S_DIV: begin
        acc_hi_nxt = step_hi_c;
        acc_lo_nxt = step_lo_c;
        cnt_nxt    = cnt + SHW'(1);
        if (cnt == SHW'(WIDTH - 1)) begin
          state_nxt  = S_FIN;
          busy_nxt   = 1'b0;
          done_nxt   = 1'b1;
          hi_nxt     = fin_hi_c;
          lo_nxt     = fin_lo_c;
          result_nxt = fin_lo_c;
          zero_nxt   = (fin_lo_c == '0);
          if (state == S_DIV) div_zero_nxt = dz;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        if (start) begin
          cnt_nxt    = '0;
          acc_hi_nxt = '0;
          neg_q_nxt  = 1'b0;
          neg_r_nxt  = 1'b0;
          dz_nxt     = 1'b0;
          if (ALUCnt == OP_MULT) begin
            state_nxt  = S_MUL;
            busy_nxt   = 1'b1;
            acc_lo_nxt = input2;
            opnd_b_nxt = input1;
          end else if (ALUCnt == OP_DIV) begin
            state_nxt  = S_DIV;
            busy_nxt   = 1'b1;
            acc_lo_nxt = input1;
            opnd_b_nxt = input2;
            opnd_a_nxt = input1;
            dz_nxt     = (input2 == '0);
`ifdef SEQ_ALU_SIGNED_EN
          end else if (ALUCnt == OP_MULTS) begin
            state_nxt  = S_MUL;
            busy_nxt   = 1'b1;
            acc_lo_nxt = mag2_c;
            opnd_b_nxt = mag1_c;
            neg_q_nxt  = input1[WIDTH-1] ^ input2[WIDTH-1];
          end else if (ALUCnt == OP_DIVS) begin
            state_nxt  = S_DIV;
            busy_nxt   = 1'b1;
            acc_lo_nxt = mag1_c;
            opnd_b_nxt = mag2_c;
            opnd_a_nxt = input1;
            dz_nxt     = (input2 == '0);
            neg_q_nxt  = input1[WIDTH-1] ^ input2[WIDTH-1];
            neg_r_nxt  = input1[WIDTH-1];
`endif
          end else begin
            result_nxt = quick_c;
            zero_nxt   = (quick_c == '0);
            done_nxt   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      opnd_b     <= '0;
      opnd_a     <= '0;
      dz         <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      ALU_result <= '0;
      Zero       <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      HI         <= '0;
      LO         <= '0;
      div_zero   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      acc_hi     <= acc_hi_nxt;
      acc_lo     <= acc_lo_nxt;
      opnd_b     <= opnd_b_nxt;
      opnd_a     <= opnd_a_nxt;
      dz         <= dz_nxt;
      neg_q      <= neg_q_nxt;
      neg_r      <= neg_r_nxt;
      ALU_result <= result_nxt;
      Zero       <= zero_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      HI         <= hi_nxt;
      LO         <= lo_nxt;
      div_zero   <= div_zero_nxt;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: constant vector table, hand-written multi-cycle sequences,
// and randomized ops against an arithmetic reference model.
module tb_seq_alu;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    ALUCnt;
  logic [W-1:0]  input1, input2;
  logic [4:0]    shamt;
  logic [W-1:0]  ALU_result, HI, LO;
  logic          Zero, busy, done, div_zero;

  seq_alu #(.WIDTH(W), .SHW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUCnt(ALUCnt),
    .input1(input1), .input2(input2), .shamt(shamt),
    .ALU_result(ALU_result), .Zero(Zero), .busy(busy), .done(done),
    .HI(HI), .LO(LO), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [W-1:0] hi_m, lo_m, exp_res;
  logic         dz_m;
  int           exp_lat;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   sh;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op at a negedge; returns latency to done (in cycles) and busy cycles seen before it
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh, input bit scramble, output int lat, output int bsy);
    @(negedge clk);
    ALUCnt = op; input1 = a; input2 = b; shamt = sh; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bsy = 0;
    while (!done && lat < 100) begin
      if (busy) bsy++;
      if (scramble) begin
        input1 = $urandom; input2 = $urandom; shamt = 5'($urandom); ALUCnt = 4'($urandom);
      end
      @(negedge clk);
      lat++;
    end
  endtask

  // Behavioural model: plain arithmetic on the architectural HI/LO/div_zero state
  task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] sh);
    logic [63:0] p;
    longint sa, sb;
    exp_lat = 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0:  exp_res = a & b;
      4'd1:  exp_res = a | b;
      4'd2:  exp_res = a + b;
      4'd3:  exp_res = a - b;
      4'd4:  exp_res = (sa < sb) ? 32'd1 : 32'd0;
      4'd5:  exp_res = ~(a | b);
      4'd6:  exp_res = b << sh;
      4'd7:  exp_res = b >> sh;
      4'd8: begin
        p = 64'(a) * 64'(b);
        hi_m = p[63:32]; lo_m = p[31:0]; exp_res = lo_m; exp_lat = W + 1;
      end
      4'd9: begin
        if (b == 0) begin lo_m = '1; hi_m = a; dz_m = 1'b1; end
        else begin lo_m = a / b; hi_m = a % b; dz_m = 1'b0; end
        exp_res = lo_m; exp_lat = W + 1;
      end
      4'd10: exp_res = hi_m;
      4'd11: exp_res = lo_m;
`ifdef SEQ_ALU_SIGNED_EN
      4'd13: begin
        p = 64'(sa * sb);
        hi_m = p[63:32]; lo_m = p[31:0]; exp_res = lo_m; exp_lat = W + 1;
      end
      4'd14: begin
        if (b == 0) begin lo_m = '1; hi_m = a; dz_m = 1'b1; end
        else begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); dz_m = 1'b0; end
        exp_res = lo_m; exp_lat = W + 1;
      end
`endif
      default: exp_res = '0;
    endcase
  endtask

  task automatic check_op(input string name, input int lat, input int bsy);
    check({name, " result"}, 64'(ALU_result), 64'(exp_res));
    check({name, " Zero"}, 64'(Zero), 64'(exp_res == 0));
    check({name, " HI"}, 64'(HI), 64'(hi_m));
    check({name, " LO"}, 64'(LO), 64'(lo_m));
    check({name, " div_zero"}, 64'(div_zero), 64'(dz_m));
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " busy cycles"}, 64'(bsy), 64'(exp_lat - 1));
  endtask

  task automatic check_reset(input string name);
    check({name, " result"}, 64'(ALU_result), 64'd0);
    check({name, " Zero"}, 64'(Zero), 64'd1);
    check({name, " busy"}, 64'(busy), 64'd0);
    check({name, " done"}, 64'(done), 64'd0);
    check({name, " HI"}, 64'(HI), 64'd0);
    check({name, " LO"}, 64'(LO), 64'd0);
    check({name, " div_zero"}, 64'(div_zero), 64'd0);
  endtask

  initial begin
    int lat, bsy, extra;
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic [4:0] sh;

    tbl[0]  = '{4'd0, 32'd3, 32'd3, 5'd1, 32'd3};
    tbl[1]  = '{4'd1, 32'd3, 32'd3, 5'd1, 32'd3};
    tbl[2]  = '{4'd2, 32'd3, 32'd3, 5'd1, 32'd6};
    tbl[3]  = '{4'd3, 32'd3, 32'd3, 5'd1, 32'd0};
    tbl[4]  = '{4'd4, 32'd3, 32'd3, 5'd1, 32'd0};
    tbl[5]  = '{4'd5, 32'd3, 32'd3, 5'd1, 32'hFFFF_FFFC};
    tbl[6]  = '{4'd6, 32'd3, 32'd3, 5'd1, 32'd6};
    tbl[7]  = '{4'd7, 32'd3, 32'd3, 5'd1, 32'd1};
    tbl[8]  = '{4'd2, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0};
    tbl[9]  = '{4'd3, 32'd0, 32'd1, 5'd0, 32'hFFFF_FFFF};
    tbl[10] = '{4'd4, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1};
    tbl[11] = '{4'd7, 32'd0, 32'h8000_0000, 5'd31, 32'd1};
    tbl[12] = '{4'd12, 32'd5, 32'd6, 5'd2, 32'd0};
    tbl[13] = '{4'd15, 32'd5, 32'd6, 5'd2, 32'd0};

    rst = 1'b1; start = 1'b0; ALUCnt = '0; input1 = '0; input2 = '0; shamt = '0;
    hi_m = '0; lo_m = '0; dz_m = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Single-cycle vector table
    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, 1'b0, lat, bsy);
      check($sformatf("tbl%0d result", i), 64'(ALU_result), 64'(tbl[i].exp));
      check($sformatf("tbl%0d Zero", i), 64'(Zero), 64'(tbl[i].exp == 0));
      check($sformatf("tbl%0d latency", i), 64'(lat), 64'd1);
    end
    check("tbl HI untouched", 64'(HI), 64'd0);
    check("tbl LO untouched", 64'(LO), 64'd0);

    // MULT then MFHI issued in the done cycle
    run_op(4'd8, 32'hFFFF_FFFF, 32'd2, 5'd0, 1'b1, lat, bsy);
    model_op(4'd8, 32'hFFFF_FFFF, 32'd2, 5'd0);
    check_op("mult", lat, bsy);
    check("mult HI const", 64'(HI), 64'd1);
    check("mult LO const", 64'(LO), 64'hFFFF_FFFE);
    ALUCnt = 4'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mfhi b2b done", 64'(done), 64'd1);
    check("mfhi b2b result", 64'(ALU_result), 64'd1);

    // DIV sequence including divide by zero and sticky-flag clear
    run_op(4'd9, 32'd100, 32'd7, 5'd0, 1'b1, lat, bsy);
    model_op(4'd9, 32'd100, 32'd7, 5'd0);
    check_op("div 100/7", lat, bsy);
    check("div 100/7 LO const", 64'(LO), 64'd14);
    check("div 100/7 HI const", 64'(HI), 64'd2);
    run_op(4'd9, 32'd5, 32'd0, 5'd0, 1'b1, lat, bsy);
    model_op(4'd9, 32'd5, 32'd0, 5'd0);
    check_op("div 5/0", lat, bsy);
    check("div 5/0 dz const", 64'(div_zero), 64'd1);
    run_op(4'd9, 32'd8, 32'd2, 5'd0, 1'b1, lat, bsy);
    model_op(4'd9, 32'd8, 32'd2, 5'd0);
    check_op("div 8/2", lat, bsy);
    check("div 8/2 dz const", 64'(div_zero), 64'd0);

    // ADD pulsed during MULT busy is ignored
    @(negedge clk);
    ALUCnt = 4'd8; input1 = 32'hFFFF_FFFF; input2 = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == 5) begin ALUCnt = 4'd2; input1 = 32'd1; input2 = 32'd1; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("ignored add latency", 64'(lat), 64'(W + 1));
    check("ignored add LO", 64'(LO), 64'hFFFF_FFFE);
    check("ignored add result", 64'(ALU_result), 64'hFFFF_FFFE);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("ignored add extra done", 64'(extra), 64'd0);

    // Reset in the middle of a DIV, after making div_zero and HI nonzero
    run_op(4'd9, 32'd5, 32'd0, 5'd0, 1'b0, lat, bsy);
    @(negedge clk);
    ALUCnt = 4'd9; input1 = 32'd100; input2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("mid-div reset");
    @(negedge clk);
    rst = 1'b0;
    hi_m = '0; lo_m = '0; dz_m = 1'b0;
    run_op(4'd2, 32'd1, 32'd1, 5'd0, 1'b0, lat, bsy);
    model_op(4'd2, 32'd1, 32'd1, 5'd0);
    check_op("add after reset", lat, bsy);
    check("add after reset const", 64'(ALU_result), 64'd2);

`ifdef SEQ_ALU_SIGNED_EN
    run_op(4'd13, -32'sd3, 32'd4, 5'd0, 1'b1, lat, bsy);
    model_op(4'd13, -32'sd3, 32'd4, 5'd0);
    check_op("mults -3*4", lat, bsy);
    check("mults HI const", 64'(HI), 64'hFFFF_FFFF);
    check("mults LO const", 64'(LO), 64'hFFFF_FFF4);
    run_op(4'd14, -32'sd7, 32'd2, 5'd0, 1'b1, lat, bsy);
    model_op(4'd14, -32'sd7, 32'd2, 5'd0);
    check_op("divs -7/2", lat, bsy);
    check("divs LO const", 64'(LO), 64'hFFFF_FFFD);
    check("divs HI const", 64'(HI), 64'hFFFF_FFFF);
    run_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b1, lat, bsy);
    model_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    check_op("divs min/-1", lat, bsy);
    check("divs min/-1 LO const", 64'(LO), 64'h8000_0000);
    check("divs min/-1 HI const", 64'(HI), 64'd0);
`endif

    // Randomized ops against the reference model
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      op = (r < 16) ? 4'(r) : ((r < 18) ? 4'd8 : 4'd9);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(20, 31);
      if ($urandom_range(0, 7) == 0) b = '0;
      sh = 5'($urandom);
      run_op(op, a, b, sh, 1'b1, lat, bsy);
      model_op(op, a, b, sh);
      check_op($sformatf("rand%0d op%0d", i, op), lat, bsy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
